// File: rtl/axi_wr_arbiter.sv
// Two-master round-robin arbiter for AXI AW+W; downstream ID gains the grant index as MSB.
// Latency: AW out 1 cycle after a request is seen in IDLE; W is a combinational pass-through in DATA.
// Backpressure: m_awready/m_wready route straight to the granted master; others see ready=0.
// Optional macro WLAST_CHECK_EN adds a sticky wlast_err output comparing master wlast to the beat count.
module axi_wr_arbiter #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [1:0]                                           s_awvalid,
    output logic [1:0]                                           s_awready,
    input  logic [2*(ID_WIDTH+ADDR_WIDTH+LEN_WIDTH)-1:0]         s_aw,
    input  logic [1:0]                                           s_wvalid,
    output logic [1:0]                                           s_wready,
    input  logic [2*(DATA_WIDTH+DATA_WIDTH/8+1)-1:0]             s_w,
    output logic                                                 m_awvalid,
    input  logic                                                 m_awready,
    output logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH:0]               m_aw,
    output logic                                                 m_wvalid,
    input  logic                                                 m_wready,
    output logic [DATA_WIDTH+DATA_WIDTH/8:0]                     m_w,
    output logic                                                 busy
`ifdef WLAST_CHECK_EN
    ,
    output logic                                                 wlast_err
`endif
);

    localparam int AW_SLICE = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH;
    localparam int W_SLICE  = DATA_WIDTH + DATA_WIDTH/8 + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   grant;
    logic                   grant_nxt;
    logic                   last_grant;
    logic                   last_grant_nxt;
    logic [LEN_WIDTH-1:0]   beat;
    logic [LEN_WIDTH-1:0]   beat_nxt;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   len_nxt;

    logic [AW_SLICE-1:0]    aw_sel;
    logic [W_SLICE-1:0]     w_sel;
    logic                   beat_last;
    logic                   w_hs;

    // Pick the granted master's AW and W slices
    always_comb begin
        aw_sel = grant ? s_aw[2*AW_SLICE-1:AW_SLICE] : s_aw[AW_SLICE-1:0];
        w_sel  = grant ? s_w[2*W_SLICE-1:W_SLICE]    : s_w[W_SLICE-1:0];
    end

    assign beat_last = (beat == len_q);

    // State and burst-tracking registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat       <= '0;
            len_q      <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat       <= beat_nxt;
            len_q      <= len_nxt;
        end
    end

    // Next-state logic and channel steering; outputs are idle unless the state drives them
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        beat_nxt       = beat;
        len_nxt        = len_q;
        s_awready      = 2'b00;
        s_wready       = 2'b00;
        m_awvalid      = 1'b0;
        m_aw           = '0;
        m_wvalid       = 1'b0;
        m_w            = '0;
        w_hs           = 1'b0;
        busy           = (state != IDLE);

        case (state)
            IDLE: begin
                // Only the registered grant steers outputs, so nothing here is combinational on AW inputs
                if (|s_awvalid) begin
                    grant_nxt = (&s_awvalid) ? ~last_grant : s_awvalid[1];
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_awvalid = 1'b1;
                m_aw      = {grant, aw_sel};
                s_awready = grant ? {m_awready, 1'b0} : {1'b0, m_awready};
                if (m_awready) begin
                    len_nxt   = aw_sel[LEN_WIDTH-1:0];
                    beat_nxt  = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                m_wvalid = s_wvalid[grant];
                s_wready = grant ? {m_wready, 1'b0} : {1'b0, m_wready};
                // wlast comes from our own beat count, never from the master
                m_w      = {w_sel[W_SLICE-1:1], beat_last};
                w_hs     = m_wvalid & m_wready;
                if (w_hs) begin
                    beat_nxt = beat + 1'b1;
                    if (beat_last) begin
                        last_grant_nxt = grant;
                        state_nxt      = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef WLAST_CHECK_EN
    // Sticky flag: master wlast disagreed with the expected last beat on some handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            wlast_err <= 1'b0;
        end else if (w_hs && (w_sel[0] != beat_last)) begin
            wlast_err <= 1'b1;
        end
    end
`else
    // Master wlast bits are deliberately ignored in this build
    logic unused_wlast;
    assign unused_wlast = s_w[0] ^ s_w[W_SLICE];
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: single burst, round-robin alternation, stalls,
// W-before-AW blocking, reset mid-burst, 16-beat bursts and (when enabled) the wlast check.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_axi_wr_arbiter;

    localparam int IDW  = 6;
    localparam int ADW  = 32;
    localparam int DW   = 32;
    localparam int LW   = 4;
    localparam int AWS  = IDW + ADW + LW;
    localparam int WS   = DW + DW/8 + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         s_awvalid;
    logic [1:0]         s_awready;
    logic [2*AWS-1:0]   s_aw;
    logic [1:0]         s_wvalid;
    logic [1:0]         s_wready;
    logic [2*WS-1:0]    s_w;
    logic               m_awvalid;
    logic               m_awready;
    logic [AWS:0]       m_aw;
    logic               m_wvalid;
    logic               m_wready;
    logic [WS-1:0]      m_w;
    logic               busy;
`ifdef WLAST_CHECK_EN
    logic               wlast_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    axi_wr_arbiter #(
        .ID_WIDTH   (IDW),
        .ADDR_WIDTH (ADW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_aw      (s_aw),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_w       (s_w),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_aw      (m_aw),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_w       (m_w),
        .busy      (busy)
`ifdef WLAST_CHECK_EN
        ,
        .wlast_err (wlast_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_aw(input int m, input logic [IDW-1:0] id, input logic [ADW-1:0] addr,
                          input logic [LW-1:0] len);
        s_aw[m*AWS +: AWS] = {id, addr, len};
    endtask

    task automatic set_w(input int m, input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                         input logic last);
        s_w[m*WS +: WS] = {data, strb, last};
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        s_awvalid = 2'b00;
        s_wvalid  = 2'b00;
        s_aw      = '0;
        s_w       = '0;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int prev;
        int n;

        // ---------------- reset state
        do_reset();
        settle();
        check("rst_m_awvalid", m_awvalid, 0);
        check("rst_m_wvalid",  m_wvalid,  0);
        check("rst_s_awready", s_awready, 0);
        check("rst_s_wready",  s_wready,  0);
        check("rst_busy",      busy,      0);
        check("rst_m_aw",      m_aw,      0);
        cyc();

        // ---------------- single master 0 burst, len=3
        set_aw(0, 6'h05, 32'h1000, 4'd3);
        s_awvalid = 2'b01;
        settle();
        check("t1_idle_awvalid", m_awvalid, 0);
        check("t1_idle_awready", s_awready, 0);
        cyc();
        set_w(0, 32'hA0, 4'hF, 1'b0);
        s_wvalid = 2'b01;
        settle();
        check("t1_addr_awvalid", m_awvalid, 1);
        check("t1_addr_m_aw",    m_aw, {1'b0, 6'h05, 32'h1000, 4'd3});
        check("t1_addr_awready", s_awready, 2'b01);
        check("t1_addr_wready",  s_wready, 2'b00);
        check("t1_addr_wvalid",  m_wvalid, 0);
        check("t1_addr_busy",    busy, 1);
        cyc();
        s_awvalid = 2'b00;
        for (int b = 0; b < 4; b++) begin
            set_w(0, 32'hA0 + 32'(b), 4'hF, 1'(b == 3));
            settle();
            check("t1_wvalid", m_wvalid, 1);
            check("t1_m_w",    m_w, {32'hA0 + 32'(b), 4'hF, 1'(b == 3)});
            check("t1_wready", s_wready, 2'b01);
            cyc();
        end
        s_wvalid = 2'b00;
        settle();
        check("t1_done_busy",   busy, 0);
        check("t1_done_wvalid", m_wvalid, 0);

        // ---------------- both masters request continuously: strict alternation
        do_reset();
        set_aw(0, 6'h11, 32'h100, 4'd0);
        set_aw(1, 6'h22, 32'h200, 4'd0);
        set_w(0, 32'h111, 4'hF, 1'b1);
        set_w(1, 32'h222, 4'hF, 1'b1);
        s_awvalid = 2'b11;
        s_wvalid  = 2'b11;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            settle();
            while (!m_awvalid && n < 10) begin
                cyc();
                settle();
                n++;
            end
            check("t2_aw_seen", m_awvalid, 1);
            check("t2_grant",   m_aw[AWS], k % 2);
            check("t2_awid",    m_aw[AWS-1 -: IDW], (k % 2) ? 6'h22 : 6'h11);
            check("t2_awready", s_awready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) check("t2_gap", cyc_cnt - prev, 3);
            prev = cyc_cnt;
            cyc();
        end
        s_awvalid = 2'b00;
        s_wvalid  = 2'b00;

        // ---------------- master 1, len=0, W stalled 3 cycles
        do_reset();
        m_wready = 1'b0;
        set_aw(1, 6'h2A, 32'h2000, 4'd0);
        s_awvalid = 2'b10;
        settle();
        cyc();
        settle();
        check("t3_m_aw",    m_aw, {1'b1, 6'h2A, 32'h2000, 4'd0});
        check("t3_awready", s_awready, 2'b10);
        cyc();
        s_awvalid = 2'b00;
        set_w(1, 32'hDEADBEEF, 4'h3, 1'b0);
        s_wvalid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_stall_wvalid", m_wvalid, 1);
            check("t3_stall_m_w",    m_w, {32'hDEADBEEF, 4'h3, 1'b1});
            check("t3_stall_wready", s_wready, 2'b00);
            cyc();
        end
        m_wready = 1'b1;
        settle();
        check("t3_go_wready", s_wready, 2'b10);
        check("t3_go_m_w",    m_w, {32'hDEADBEEF, 4'h3, 1'b1});
        cyc();
        s_wvalid = 2'b00;
        settle();
        check("t3_done_busy", busy, 0);

        // ---------------- master 1 W before its AW while master 0 is in DATA
        do_reset();
        set_aw(0, 6'h01, 32'h3000, 4'd1);
        set_aw(1, 6'h02, 32'h4000, 4'd1);
        set_w(0, 32'h30, 4'hF, 1'b0);
        set_w(1, 32'h40, 4'hF, 1'b0);
        s_awvalid = 2'b01;
        s_wvalid  = 2'b10;
        settle();
        check("t4_idle_wready", s_wready, 2'b00);
        cyc();
        settle();
        check("t4_addr0_wready", s_wready, 2'b00);
        check("t4_addr0_grant",  m_aw[AWS], 0);
        cyc();
        s_awvalid = 2'b10;
        s_wvalid  = 2'b11;
        for (int b = 0; b < 2; b++) begin
            set_w(0, 32'h30 + 32'(b), 4'hF, 1'(b == 1));
            settle();
            check("t4_d0_wready",  s_wready, 2'b01);
            check("t4_d0_awready", s_awready, 2'b00);
            check("t4_d0_data",    m_w[WS-1 -: DW], 32'h30 + 32'(b));
            cyc();
        end
        s_wvalid = 2'b10;
        settle();
        check("t4_gap_wready", s_wready, 2'b00);
        check("t4_gap_busy",   busy, 0);
        cyc();
        settle();
        check("t4_addr1_awready", s_awready, 2'b10);
        check("t4_addr1_wready",  s_wready, 2'b00);
        check("t4_addr1_wvalid",  m_wvalid, 0);
        check("t4_addr1_m_aw",    m_aw, {1'b1, 6'h02, 32'h4000, 4'd1});
        cyc();
        s_awvalid = 2'b00;
        for (int b = 0; b < 2; b++) begin
            set_w(1, 32'h40 + 32'(b), 4'hF, 1'(b == 1));
            settle();
            check("t4_d1_wready", s_wready, 2'b10);
            check("t4_d1_data",   m_w[WS-1 -: DW], 32'h40 + 32'(b));
            check("t4_d1_wlast",  m_w[0], 1'(b == 1));
            cyc();
        end
        s_wvalid = 2'b00;
        settle();
        check("t4_done_busy", busy, 0);

        // ---------------- reset on beat 2 of a len=7 burst
        do_reset();
        set_aw(0, 6'h07, 32'h5000, 4'd7);
        s_awvalid = 2'b01;
        settle();
        cyc();
        settle();
        cyc();
        s_awvalid = 2'b00;
        s_wvalid  = 2'b01;
        for (int b = 0; b < 2; b++) begin
            set_w(0, 32'(b), 4'hF, 1'b0);
            settle();
            check("t5_pre_wlast", m_w[0], 0);
            cyc();
        end
        set_w(0, 32'd2, 4'hF, 1'b0);
        settle();
        check("t5_beat2_wvalid", m_wvalid, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        check("t5_rst_wvalid",  m_wvalid, 0);
        check("t5_rst_wready",  s_wready, 2'b00);
        check("t5_rst_awvalid", m_awvalid, 0);
        check("t5_rst_awready", s_awready, 2'b00);
        check("t5_rst_busy",    busy, 0);
        cyc();
        s_wvalid = 2'b00;
        set_aw(1, 6'h09, 32'h6000, 4'd2);
        s_awvalid = 2'b10;
        settle();
        cyc();
        settle();
        check("t5_new_m_aw", m_aw, {1'b1, 6'h09, 32'h6000, 4'd2});
        cyc();
        s_awvalid = 2'b00;
        s_wvalid  = 2'b10;
        for (int b = 0; b < 3; b++) begin
            set_w(1, 32'h60 + 32'(b), 4'hF, 1'b0);
            settle();
            check("t5_new_wlast", m_w[0], 1'(b == 2));
            cyc();
        end
        s_wvalid = 2'b00;
        settle();
        check("t5_new_busy", busy, 0);

        // ---------------- len=15: 16 beats without counter wrap
        do_reset();
        set_aw(0, 6'h3F, 32'hFFFF_FFF0, 4'hF);
        s_awvalid = 2'b01;
        settle();
        cyc();
        settle();
        check("t6_m_aw", m_aw, {1'b0, 6'h3F, 32'hFFFF_FFF0, 4'hF});
        cyc();
        s_awvalid = 2'b00;
        s_wvalid  = 2'b01;
        for (int b = 0; b < 16; b++) begin
            set_w(0, 32'(b), 4'hF, 1'(b == 15));
            settle();
            check("t6_wvalid", m_wvalid, 1);
            check("t6_wlast",  m_w[0], 1'(b == 15));
            cyc();
        end
        s_wvalid = 2'b00;
        settle();
        check("t6_done_busy", busy, 0);

`ifdef WLAST_CHECK_EN
        // ---------------- early master wlast flags an error but burst length holds
        do_reset();
        settle();
        check("t7_rst_err", wlast_err, 0);
        set_aw(0, 6'h0C, 32'h7000, 4'd3);
        s_awvalid = 2'b01;
        cyc();
        settle();
        cyc();
        s_awvalid = 2'b00;
        s_wvalid  = 2'b01;
        for (int b = 0; b < 4; b++) begin
            set_w(0, 32'h70 + 32'(b), 4'hF, 1'(b == 1));
            settle();
            check("t7_err", wlast_err, (b >= 2) ? 1 : 0);
            check("t7_wlast", m_w[0], 1'(b == 3));
            check("t7_busy", busy, 1);
            cyc();
        end
        s_wvalid = 2'b00;
        settle();
        check("t7_done_busy", busy, 0);
        check("t7_sticky",    wlast_err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
